// File: rtl/dram_access_unit_pkg.sv
// Shared encodings for the DRAM access unit.
// Size codes, control bits and FSM states.
package dram_access_unit_pkg;

    localparam logic [1:0] DRAM_SZ_B = 2'd0;
    localparam logic [1:0] DRAM_SZ_H = 2'd1;
    localparam logic [1:0] DRAM_SZ_W = 2'd2;
    localparam int DRAM_CTRL_UNS = 2;

    localparam logic [1:0] DAU_IDLE = 2'd0;
    localparam logic [1:0] DAU_ACC0 = 2'd1;
    localparam logic [1:0] DAU_ACC1 = 2'd2;
    localparam logic [1:0] DAU_DONE = 2'd3;

    function automatic logic [3:0] size_mask(
        input logic [1:0] sz
    );
        case (sz)
            DRAM_SZ_B: return 4'h1;
            DRAM_SZ_H: return 4'h3;
            default:   return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/dram_lane_align.sv
// Byte-lane placement for stores and
// extraction/extension for loads.
module dram_lane_align
    import dram_access_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  ctrl,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata64,
    output logic [7:0]  be64,
    output logic [63:0] wd64,
    output logic        split,
    output logic [31:0] rd
);

    logic [63:0] sh;
    logic        uns;

    // Shift enables/data into the 8-byte window, pull load data back out
    always_comb begin
        be64  = {4'h0, size_mask(ctrl[1:0])} << off;
        wd64  = {32'h0, wdata} << {off, 3'b000};
        split = |be64[7:4];
        sh    = rdata64 >> {off, 3'b000};
        uns   = ctrl[DRAM_CTRL_UNS];
        case (ctrl[1:0])
            DRAM_SZ_B:
                rd = uns ? {24'h0, sh[7:0]}
                         : {{24{sh[7]}}, sh[7:0]};
            DRAM_SZ_H:
                rd = uns ? {16'h0, sh[15:0]}
                         : {{16{sh[15]}}, sh[15:0]};
            default:
                rd = sh[31:0];
        endcase
    end

endmodule

// File: rtl/dram_access_unit.sv
// Turns arbitrated DRAM requests into one or
// two byte-enabled 32-bit word transactions.
module dram_access_unit
    import dram_access_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] w_dram_addr,
    input  logic [31:0] w_dram_wdata,
    input  logic        w_dram_we_t,
    input  logic        w_dram_le,
    input  logic [2:0]  w_dram_ctrl,
    output logic        w_dram_busy,
    output logic [31:0] w_dram_odata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(ACK_TIMEOUT - 1);

    logic [1:0]       state;
    logic [31:0]      a_addr;
    logic [31:0]      a_wdata;
    logic [2:0]       a_ctrl;
    logic             a_we;
    logic             we_ref;
    logic             ld_pend;
    logic [31:0]      r0;
    logic [31:0]      r1;
    logic [CNT_W-1:0] cnt;

    logic        st;
    logic        ld;
    logic        in0;
    logic        in1;
    logic [7:0]  be64;
    logic [63:0] wd64;
    logic        split;
    logic [31:0] rd;

    dram_lane_align u_lane (
        .off     (a_addr[1:0]),
        .ctrl    (a_ctrl),
        .wdata   (a_wdata),
        .rdata64 ({r1, r0}),
        .be64    (be64),
        .wd64    (wd64),
        .split   (split),
        .rd      (rd)
    );

    // Start detect and word-port drive from the current state
    always_comb begin
        st          = (w_dram_we_t != we_ref);
        ld          = w_dram_le | ld_pend;
        w_dram_busy = (state != DAU_IDLE) | st | ld;
        in0         = (state == DAU_ACC0);
        in1         = (state == DAU_ACC1);
        mem_req     = in0 | in1;
        mem_we      = mem_req & a_we;
        mem_addr    = 30'h0;
        mem_be      = 4'h0;
        mem_wdata   = 32'h0;
        if (in0) begin
            mem_addr  = a_addr[31:2];
            mem_be    = be64[3:0];
            mem_wdata = wd64[31:0];
        end else if (in1) begin
            mem_addr  = a_addr[31:2] + 30'd1;
            mem_be    = be64[7:4];
            mem_wdata = wd64[63:32];
        end
    end

    // Request sequencing, ack capture and timeout abort
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state        <= DAU_IDLE;
            a_addr       <= 32'h0;
            a_wdata      <= 32'h0;
            a_ctrl       <= 3'h0;
            a_we         <= 1'b0;
            we_ref       <= 1'b0;
            ld_pend      <= 1'b0;
            r0           <= 32'h0;
            r1           <= 32'h0;
            cnt          <= '0;
            w_dram_odata <= 32'h0;
            err_timeout  <= 1'b0;
        end else begin
            unique case (state)
                DAU_IDLE: begin
                    if (st || ld) begin
                        state   <= DAU_ACC0;
                        cnt     <= '0;
                        r0      <= 32'h0;
                        r1      <= 32'h0;
                        a_addr  <= w_dram_addr;
                        a_wdata <= w_dram_wdata;
                        a_ctrl  <= w_dram_ctrl;
                        a_we    <= st;
                        ld_pend <= st & ld;
                        if (st) we_ref <= w_dram_we_t;
                    end
                end
                DAU_ACC0: begin
                    if (mem_ack) begin
                        if (!a_we) r0 <= mem_rdata;
                        cnt   <= '0;
                        state <= split ? DAU_ACC1 : DAU_DONE;
                    end else if (cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= DAU_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DAU_ACC1: begin
                    if (mem_ack) begin
                        if (!a_we) r1 <= mem_rdata;
                        state <= DAU_DONE;
                    end else if (cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= DAU_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DAU_DONE: begin
                    if (!a_we) w_dram_odata <= rd;
                    state <= DAU_IDLE;
                end
                default: state <= DAU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_access_unit.sv
// Scoreboard bench for dram_access_unit.
// Word port and load results checked by monitors.
module tb_dram_access_unit;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic [31:0] w_dram_addr = 32'h0;
    logic [31:0] w_dram_wdata = 32'h0;
    logic        w_dram_we_t = 1'b0;
    logic        w_dram_le = 1'b0;
    logic [2:0]  w_dram_ctrl = 3'h0;
    logic        w_dram_busy;
    logic [31:0] w_dram_odata;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        err_timeout;

    always #5 CLK = ~CLK;

    dram_access_unit dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .w_dram_addr  (w_dram_addr),
        .w_dram_wdata (w_dram_wdata),
        .w_dram_we_t  (w_dram_we_t),
        .w_dram_le    (w_dram_le),
        .w_dram_ctrl  (w_dram_ctrl),
        .w_dram_busy  (w_dram_busy),
        .w_dram_odata (w_dram_odata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .err_timeout  (err_timeout)
    );

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [31:0] odata;
        int          busy;
    } ep_t;

    txn_t exp_txn[$];
    ep_t  exp_ep[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   budget = -1;
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] rdw(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic et(input logic we, input logic [29:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
        txn_t t;
        t.we = we; t.addr = a; t.be = be; t.wdata = wd;
        exp_txn.push_back(t);
    endtask

    task automatic ee(input logic [31:0] od, input int busy);
        ep_t e;
        e.odata = od; e.busy = busy;
        exp_ep.push_back(e);
    endtask

    // Memory responder: ack in the first req cycle while budget allows
    always @(negedge CLK) begin
        if (mem_req && budget != 0) begin
            mem_ack = 1'b1;
            mem_rdata = rdw(mem_addr);
            if (budget > 0) budget--;
        end else begin
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
        end
    end

    // Transaction monitor: compare each acked word, then commit writes
    txn_t mt;
    always begin
        @(negedge CLK); #1;
        if (RST_X && mem_req && mem_ack) begin
            n_tests++;
            if (exp_txn.size() == 0) begin
                n_fail++;
                $display("FAIL txn_unexpected got we=%0b addr=%h be=%h",
                         mem_we, mem_addr, mem_be);
            end else begin
                mt = exp_txn.pop_front();
                if (mem_we !== mt.we || mem_addr !== mt.addr ||
                    mem_be !== mt.be ||
                    (mt.we && mem_wdata !== mt.wdata)) begin
                    n_fail++;
                    $display("FAIL txn got we=%0b a=%h be=%h wd=%h expected we=%0b a=%h be=%h wd=%h",
                             mem_we, mem_addr, mem_be, mem_wdata,
                             mt.we, mt.addr, mt.be, mt.wdata);
                end
            end
            if (mem_we) begin
                logic [31:0] w;
                w = rdw(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr] = w;
            end
        end
    end

    // Episode monitor: on busy falling, check odata and busy length
    int   bcnt = 0;
    logic pb = 1'b0;
    ep_t  me;
    always begin
        @(negedge CLK); #1;
        if (!RST_X) begin
            bcnt = 0;
            pb = 1'b0;
        end else begin
            if (w_dram_busy) begin
                bcnt++;
            end else if (pb) begin
                n_tests++;
                if (exp_ep.size() == 0) begin
                    n_fail++;
                    $display("FAIL ep_unexpected got odata=%h busy=%0d",
                             w_dram_odata, bcnt);
                end else begin
                    me = exp_ep.pop_front();
                    if (w_dram_odata !== me.odata || bcnt != me.busy) begin
                        n_fail++;
                        $display("FAIL ep got odata=%h busy=%0d expected odata=%h busy=%0d",
                                 w_dram_odata, bcnt, me.odata, me.busy);
                    end
                end
                bcnt = 0;
            end
            pb = w_dram_busy;
        end
    end

    task automatic wait_idle(input int lim);
        int k = 0;
        while (w_dram_busy && k < lim) begin
            @(posedge CLK); #1;
            k++;
        end
        if (w_dram_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_wait got busy=1 expected busy=0");
        end
        @(posedge CLK);
    endtask

    task automatic op(input logic do_st, input logic do_ld,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] c);
        @(posedge CLK); #1;
        w_dram_addr = a;
        w_dram_wdata = wd;
        w_dram_ctrl = c;
        if (do_st) w_dram_we_t = ~w_dram_we_t;
        w_dram_le = do_ld;
        @(posedge CLK); #1;
        w_dram_le = 1'b0;
        wait_idle(600);
    endtask

    int reqc;
    int k;

    initial begin
        #12;
        chk("rst_busy", {31'h0, w_dram_busy}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_odata", w_dram_odata, 32'h0);
        chk("rst_err", {31'h0, err_timeout}, 32'h0);
        chk("rst_addr_be", {mem_addr, mem_be[1:0]}, 32'h0);
        @(posedge CLK); #1;
        RST_X = 1'b1;

        // aligned word store then load
        et(1, 30'h20000400, 4'hF, 32'hDEADBEEF); ee(32'h0, 3);
        op(1, 0, 32'h80001000, 32'hDEADBEEF, 3'd2);
        et(0, 30'h20000400, 4'hF, 32'h0); ee(32'hDEADBEEF, 3);
        op(0, 1, 32'h80001000, 32'h0, 3'd2);

        // byte store, signed and unsigned byte loads
        et(1, 30'h20000400, 4'h8, 32'h80000000); ee(32'hDEADBEEF, 3);
        op(1, 0, 32'h80001003, 32'h00000080, 3'd0);
        et(0, 30'h20000400, 4'h8, 32'h0); ee(32'hFFFFFF80, 3);
        op(0, 1, 32'h80001003, 32'h0, 3'd0);
        et(0, 30'h20000400, 4'h8, 32'h0); ee(32'h00000080, 3);
        op(0, 1, 32'h80001003, 32'h0, 3'd4);

        // misaligned half store and loads across two words
        et(1, 30'h20000400, 4'h8, 32'h34000000);
        et(1, 30'h20000401, 4'h1, 32'h00000012);
        ee(32'h00000080, 4);
        op(1, 0, 32'h80001003, 32'h00001234, 3'd1);
        et(0, 30'h20000400, 4'h8, 32'h0);
        et(0, 30'h20000401, 4'h1, 32'h0);
        ee(32'h00001234, 4);
        op(0, 1, 32'h80001003, 32'h0, 3'd1);
        et(0, 30'h20000400, 4'hE, 32'h0);
        et(0, 30'h20000401, 4'h1, 32'h0);
        ee(32'h1234ADBE, 4);
        op(0, 1, 32'h80001001, 32'h0, 3'd2);

        // negative half, signed vs unsigned
        et(1, 30'h20000800, 4'hC, 32'hFF800000); ee(32'h1234ADBE, 3);
        op(1, 0, 32'h80002002, 32'h0000FF80, 3'd1);
        et(0, 30'h20000800, 4'hC, 32'h0); ee(32'hFFFFFF80, 3);
        op(0, 1, 32'h80002002, 32'h0, 3'd1);
        et(0, 30'h20000800, 4'hC, 32'h0); ee(32'h0000FF80, 3);
        op(0, 1, 32'h80002002, 32'h0, 3'd5);

        // split at the top of the address space wraps to word 0
        et(1, 30'h3FFFFFFF, 4'h8, 32'hCD000000);
        et(1, 30'h00000000, 4'h1, 32'h000000AB);
        ee(32'h0000FF80, 4);
        op(1, 0, 32'hFFFFFFFF, 32'h0000ABCD, 3'd1);
        et(0, 30'h3FFFFFFF, 4'h8, 32'h0);
        et(0, 30'h00000000, 4'h1, 32'h0);
        ee(32'hFFFFABCD, 4);
        op(0, 1, 32'hFFFFFFFF, 32'h0, 3'd1);

        // simultaneous store toggle and load pulse
        et(1, 30'h20000C00, 4'hF, 32'hCAFEF00D);
        et(0, 30'h20000C00, 4'hF, 32'h0);
        ee(32'hCAFEF00D, 6);
        op(1, 1, 32'h80003000, 32'hCAFEF00D, 3'd2);

        // ack never arrives
        budget = 0;
        ee(32'h0, 257);
        @(posedge CLK); #1;
        w_dram_addr = 32'h80004000;
        w_dram_ctrl = 3'd2;
        w_dram_le = 1'b1;
        reqc = 0;
        k = 0;
        do begin
            @(posedge CLK); #1;
            w_dram_le = 1'b0;
            if (mem_req) reqc++;
            k++;
        end while (w_dram_busy && k < 600);
        chk("to_req_cycles", reqc, 255);
        chk("to_err", {31'h0, err_timeout}, 32'h1);
        chk("to_busy", {31'h0, w_dram_busy}, 32'h0);
        @(posedge CLK);

        // reset while the second word is outstanding
        budget = 1;
        et(1, 30'h20001400, 4'h8, 32'h66000000);
        @(posedge CLK); #1;
        w_dram_addr = 32'h80005003;
        w_dram_wdata = 32'h00005566;
        w_dram_ctrl = 3'd1;
        w_dram_we_t = ~w_dram_we_t;
        k = 0;
        do begin
            @(posedge CLK); #1;
            k++;
        end while (!(mem_req && mem_addr == 30'h20001401) && k < 20);
        chk("acc1_reached", {2'b0, mem_addr}, 32'h20001401);
        #2;
        RST_X = 1'b0;
        w_dram_we_t = 1'b0;
        #1;
        chk("rst_async_req", {31'h0, mem_req}, 32'h0);
        chk("rst_txn_left", exp_txn.size(), 0);
        exp_ep.delete();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_err_clr", {31'h0, err_timeout}, 32'h0);
        chk("rst_odata_clr", w_dram_odata, 32'h0);
        RST_X = 1'b1;
        budget = -1;
        reqc = 0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (mem_req || w_dram_busy) reqc++;
        end
        chk("no_spurious", reqc, 0);

        // normal operation resumes
        et(0, 30'h20000400, 4'hF, 32'h0); ee(32'h34ADBEEF, 3);
        op(0, 1, 32'h80001000, 32'h0, 3'd2);

        repeat (4) @(posedge CLK);
        chk("txn_queue_empty", exp_txn.size(), 0);
        chk("ep_queue_empty", exp_ep.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
